// File: rtl/button_event_pkg.sv
// Shared types for the button event controller: event record, grant-lock states
// and the width helper for the per-lane stability counter.
package button_event_pkg;

   localparam int ID_MAX_W = 8;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic                press;
   } event_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

   function automatic int lane_cnt_width(input int stable_ticks);
      return safe_clog2(stable_ticks + 1);
   endfunction

endpackage

// File: rtl/button_event_lane.sv
// One button lane: synchronizer, tick-based debounce counter, debounced level and
// pending-event slot. BUTTON_EVENT_CTRL_RELEASE_EN also turns releases into events.
module button_event_lane
   import button_event_pkg::*;
#(
   parameter int stable_ticks_p = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   input  logic tick,
   input  logic accept,
   output logic state,
   output logic pend,
   output logic ev_type,
   output logic ovf_pulse
);

   localparam int CNT_W = lane_cnt_width(stable_ticks_p);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(stable_ticks_p - 1);

   logic [1:0]       sync_reg;
   logic [1:0]       vld_reg;
   logic             armed_reg, armed_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             state_reg, state_next;
   logic             pend_reg, pend_next;
   logic             type_reg, type_next;
   logic             sync;
   logic             differ;
   logic             flip;
   logic             raise;

   assign sync = sync_reg[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg  <= '0;
         vld_reg   <= '0;
         armed_reg <= 1'b0;
         cnt_reg   <= '0;
         state_reg <= 1'b0;
         pend_reg  <= 1'b0;
         type_reg  <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[0], button};
         vld_reg   <= {vld_reg[0], 1'b1};
         armed_reg <= armed_next;
         cnt_reg   <= cnt_next;
         state_reg <= state_next;
         pend_reg  <= pend_next;
         type_reg  <= type_next;
      end
   end

   // A lane stays disarmed after reset until its synchronized input is seen low,
   // so a button held through reset cannot produce a press.
   always_comb begin
      armed_next = armed_reg | (vld_reg[1] & ~sync);
      differ     = armed_reg & (sync != state_reg);
      flip       = differ & tick & (cnt_reg == CNT_LAST);
      cnt_next   = cnt_reg;
      if (!differ)
         cnt_next = '0;
      else if (tick)
         cnt_next = flip ? '0 : cnt_reg + 1'b1;
      state_next = flip ? sync : state_reg;
`ifdef BUTTON_EVENT_CTRL_RELEASE_EN
      raise = flip;
`else
      raise = flip & sync;
`endif
      pend_next = raise | (pend_reg & ~accept);
      type_next = raise ? sync : type_reg;
      ovf_pulse = raise & pend_reg & ~accept;
   end

   assign state   = state_reg;
   assign pend    = pend_reg;
   assign ev_type = type_reg;

endmodule

// File: rtl/button_event_ctrl.sv
// Debounce-and-event controller: shared tick prescaler, per-lane debouncers, round-robin
// event port with grant lock and sticky overflow. Optional macro: BUTTON_EVENT_CTRL_RELEASE_EN.
module button_event_ctrl
   import button_event_pkg::*;
#(
   parameter int num_buttons_p    = 4,
   parameter int prescale_width_p = 11,
   parameter int stable_ticks_p   = 4
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic [num_buttons_p-1:0]              buttons_i,
   output logic [num_buttons_p-1:0]              state_o,
   output logic                                  v_o,
   input  logic                                  ready_i,
   output logic [safe_clog2(num_buttons_p)-1:0]  id_o,
   output logic                                  press_o,
   output logic                                  overflow_o
);

   localparam int ID_W = safe_clog2(num_buttons_p);

   logic [prescale_width_p-1:0] prescale_reg;
   logic                        tick;
   logic [num_buttons_p-1:0]    pend, ev_type, ovf_pulse, accept;
   logic [ID_W-1:0]             rr_reg;
   logic [ID_W-1:0]             grant;
   logic [ID_W-1:0]             id_sel;
   logic                        found;
   int                          idx;
   lock_state_t                 lock_reg, lock_next;
   logic [ID_MAX_W-1:0]         lock_id_reg, lock_id_next;
   logic                        overflow_reg;
   event_t                      ev;

   assign tick = &prescale_reg;

   generate
      for (genvar gi = 0; gi < num_buttons_p; gi++) begin : g_lane
         assign accept[gi] = v_o & ready_i & (ev.id == ID_MAX_W'(gi));
         button_event_lane #(
            .stable_ticks_p (stable_ticks_p)
         ) u_lane (
            .clk       (clk_i),
            .rst       (reset_i),
            .button    (buttons_i[gi]),
            .tick      (tick),
            .accept    (accept[gi]),
            .state     (state_o[gi]),
            .pend      (pend[gi]),
            .ev_type   (ev_type[gi]),
            .ovf_pulse (ovf_pulse[gi])
         );
      end
   endgenerate

   // First pending lane at or after the round-robin pointer, wrapping.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < num_buttons_p; k++) begin
         idx = (int'(rr_reg) + k) % num_buttons_p;
         if (!found && pend[idx]) begin
            found = 1'b1;
            grant = ID_W'(idx);
         end
      end
   end

   always_comb begin
      ev.id        = (lock_reg == LOCKED) ? lock_id_reg : ID_MAX_W'(grant);
      id_sel       = ev.id[ID_W-1:0];
      ev.press     = ev_type[id_sel];
      v_o          = (|pend) | (lock_reg == LOCKED);
      lock_next    = lock_reg;
      lock_id_next = lock_id_reg;
      case (lock_reg)
         IDLE: begin
            if (v_o && !ready_i) begin
               lock_next    = LOCKED;
               lock_id_next = ev.id;
            end
         end
         LOCKED: begin
            if (ready_i)
               lock_next = IDLE;
         end
         default: lock_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         prescale_reg <= '0;
         rr_reg       <= '0;
         lock_reg     <= IDLE;
         lock_id_reg  <= '0;
         overflow_reg <= 1'b0;
      end else begin
         prescale_reg <= prescale_reg + 1'b1;
         lock_reg     <= lock_next;
         lock_id_reg  <= lock_id_next;
         overflow_reg <= overflow_reg | (|ovf_pulse);
         if (v_o && ready_i)
            rr_reg <= (id_sel == ID_W'(num_buttons_p - 1)) ? '0 : id_sel + 1'b1;
      end
   end

   assign id_o       = id_sel;
   assign press_o    = ev.press;
   assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed self-checking bench for button_event_ctrl (4 lanes, 4-cycle tick, 3 stable ticks);
// expectations follow BUTTON_EVENT_CTRL_RELEASE_EN when it is defined.
module tb_button_event_ctrl;

   localparam int NB = 4;
   localparam int PW = 2;
   localparam int ST = 3;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [NB-1:0] buttons_i;
   logic [NB-1:0] state_o;
   logic          v_o;
   logic          ready_i;
   logic [1:0]    id_o;
   logic          press_o;
   logic          overflow_o;

   int assert_count = 0;
   int fail_count   = 0;
   int n;
   logic seen_v, seen_s, moved;

   always #5 clk_i = ~clk_i;

   button_event_ctrl #(
      .num_buttons_p    (NB),
      .prescale_width_p (PW),
      .stable_ticks_p   (ST)
   ) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .buttons_i  (buttons_i),
      .state_o    (state_o),
      .v_o        (v_o),
      .ready_i    (ready_i),
      .id_o       (id_o),
      .press_o    (press_o),
      .overflow_o (overflow_o)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: got %0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) step();
   endtask

   task automatic wait_state(input int lane, input logic level, input int max, output int cnt);
      cnt = 0;
      while (state_o[lane] !== level && cnt < max) begin
         step();
         cnt++;
      end
   endtask

   task automatic wait_valid(input int max, output int cnt);
      cnt = 0;
      while (v_o !== 1'b1 && cnt < max) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      reset_i   = 1'b1;
      buttons_i = '0;
      ready_i   = 1'b1;
      #1;
      check_value("reset_state", 32'(state_o), 32'h0);
      check_value("reset_v", 32'(v_o), 32'h0);
      check_value("reset_id", 32'(id_o), 32'h0);
      check_value("reset_press", 32'(press_o), 32'h0);
      check_value("reset_ovf", 32'(overflow_o), 32'h0);
      idle(2);
      reset_i = 1'b0;
      idle(3);

      // clean press on lane 2
      buttons_i[2] = 1'b1;
      wait_state(2, 1'b1, 40, n);
      check_value("press_latency_in_range", 32'(n >= 11 && n <= 14), 32'h1);
      check_value("press_state", 32'(state_o), 32'h4);
      check_value("press_v", 32'(v_o), 32'h1);
      check_value("press_id", 32'(id_o), 32'h2);
      check_value("press_type", 32'(press_o), 32'h1);
      step();
      check_value("press_v_one_cycle", 32'(v_o), 32'h0);
      buttons_i[2] = 1'b0;
      wait_state(2, 1'b0, 40, n);
      check_value("release_state", 32'(state_o), 32'h0);
`ifdef BUTTON_EVENT_CTRL_RELEASE_EN
      check_value("release_v", 32'(v_o), 32'h1);
      check_value("release_type", 32'(press_o), 32'h0);
`else
      check_value("release_no_event", 32'(v_o), 32'h0);
`endif
      idle(5);

      // glitch rejection
      buttons_i[0] = 1'b1;
      idle(3);
      buttons_i[0] = 1'b0;
      seen_v = 1'b0;
      seen_s = 1'b0;
      repeat (30) begin
         step();
         seen_v |= v_o;
         seen_s |= state_o[0];
      end
      check_value("glitch_no_valid", 32'(seen_v), 32'h0);
      check_value("glitch_no_state", 32'(seen_s), 32'h0);

      // round-robin, starting from rr = 0
      reset_i = 1'b1;
      #2;
      reset_i = 1'b0;
      idle(3);
      for (int burst = 0; burst < 2; burst++) begin
         buttons_i = 4'b1011;
         wait_valid(40, n);
         check_value($sformatf("rr%0d_v", burst), 32'(v_o), 32'h1);
         check_value($sformatf("rr%0d_first", burst), 32'(id_o), 32'h0);
         check_value($sformatf("rr%0d_press", burst), 32'(press_o), 32'h1);
         step();
         check_value($sformatf("rr%0d_second", burst), 32'(id_o), 32'h1);
         step();
         check_value($sformatf("rr%0d_third", burst), 32'(id_o), 32'h3);
         step();
         check_value($sformatf("rr%0d_drained", burst), 32'(v_o), 32'h0);
         buttons_i = '0;
         wait_state(0, 1'b0, 40, n);
         idle(6);
      end

      // backpressure
      ready_i      = 1'b0;
      buttons_i[3] = 1'b1;
      wait_valid(40, n);
      check_value("bp_first_id", 32'(id_o), 32'h3);
      buttons_i[0] = 1'b1;
      moved = 1'b0;
      n = 0;
      while (state_o[0] !== 1'b1 && n < 40) begin
         step();
         n++;
         if (id_o !== 2'd3 || v_o !== 1'b1) moved = 1'b1;
      end
      check_value("bp_lane0_debounced", 32'(state_o[0]), 32'h1);
      check_value("bp_id_held", 32'(moved), 32'h0);
      check_value("bp_id_still_3", 32'(id_o), 32'h3);
      ready_i = 1'b1;
      step();
      check_value("bp_next_v", 32'(v_o), 32'h1);
      check_value("bp_next_id", 32'(id_o), 32'h0);
      step();
      check_value("bp_drained", 32'(v_o), 32'h0);
      buttons_i = '0;
      wait_state(3, 1'b0, 40, n);
      idle(6);

      // overflow: press then release lane 1 while stalled
      ready_i      = 1'b0;
      buttons_i[1] = 1'b1;
      wait_state(1, 1'b1, 40, n);
      check_value("ovf_press_id", 32'(id_o), 32'h1);
      buttons_i[1] = 1'b0;
      wait_state(1, 1'b0, 40, n);
      check_value("ovf_released", 32'(state_o[1]), 32'h0);
      check_value("ovf_id_held", 32'(id_o), 32'h1);
`ifdef BUTTON_EVENT_CTRL_RELEASE_EN
      check_value("ovf_flag", 32'(overflow_o), 32'h1);
      check_value("ovf_type", 32'(press_o), 32'h0);
`else
      check_value("ovf_flag", 32'(overflow_o), 32'h0);
      check_value("ovf_type", 32'(press_o), 32'h1);
`endif
      ready_i = 1'b1;
      step();
      check_value("ovf_drained", 32'(v_o), 32'h0);

      // asynchronous reset with an event pending
      ready_i      = 1'b0;
      buttons_i[2] = 1'b1;
      wait_valid(40, n);
      check_value("ar_pending", 32'(v_o), 32'h1);
      #3;
      reset_i = 1'b1;
      #1;
      check_value("ar_v", 32'(v_o), 32'h0);
      check_value("ar_state", 32'(state_o), 32'h0);
      check_value("ar_ovf", 32'(overflow_o), 32'h0);
      #2;
      reset_i = 1'b0;
      ready_i = 1'b1;
      seen_v  = 1'b0;
      repeat (40) begin
         step();
         seen_v |= v_o;
      end
      check_value("ar_held_no_event", 32'(seen_v), 32'h0);
      buttons_i[2] = 1'b0;
      idle(10);
      buttons_i[2] = 1'b1;
      wait_valid(40, n);
      check_value("ar_repress_v", 32'(v_o), 32'h1);
      check_value("ar_repress_id", 32'(id_o), 32'h2);
      check_value("ar_repress_type", 32'(press_o), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
